// File: rtl/arith_pkg.sv
// Shared types for the arithmetic op sequencer: command opcodes and FSM states.
package arith_pkg;

  typedef enum logic [2:0] {
    OP_ONES   = 3'd0,
    OP_TWOS   = 3'd1,
    OP_SQUARE = 3'd2,
    OP_MULT   = 3'd3,
    OP_SMUL2  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, always WIDTH cycles.
module shift_add_mul
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               active_q;
  logic [2*WIDTH-1:0] acc_next;

  assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign done     = active_q && (cnt_q == CW'(WIDTH - 1));
  // The caller captures the product on the same edge the last partial sum lands.
  assign product  = acc_next;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (clear) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, multiplicand};
      mplier_q <= multiplier;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/arith_op_sequencer.sv
// One-command-at-a-time arithmetic sequencer with valid/ready on command and result sides.
module arith_op_sequencer
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               err,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] result_q;
  logic               err_q;
  logic [2*WIDTH-1:0] single_res;
  logic [2*WIDTH-1:0] mul_product;
  logic               mul_done;
  logic               is_mul;
  logic               legal;
  logic               accept;
  logic               retire;

  assign is_mul    = (op == OP_SQUARE) || (op == OP_MULT);
  assign legal     = (op <= OP_SMUL2);
  assign accept    = in_valid && (state_q == IDLE);
  assign retire    = out_ready && (state_q == DONE);
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign err       = err_q;

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (accept && is_mul),
    .clear        (retire),
    .multiplicand (a),
    .multiplier   ((op == OP_SQUARE) ? a : b),
    .done         (mul_done),
    .product      (mul_product)
  );

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    single_res = '0;
    case (op)
      OP_ONES:  single_res = {{WIDTH{1'b0}}, ~a};
      OP_TWOS:  single_res = {{WIDTH{1'b0}}, ~a + WIDTH'(1)};
      // Doubling keeps the low WIDTH bits, so the new sign bit is a[WIDTH-2].
      OP_SMUL2: single_res = {{WIDTH{a[WIDTH-2]}}, a[WIDTH-2:0], 1'b0};
      default:  single_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = is_mul ? MUL : DONE;
      MUL:     if (mul_done) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      err_q    <= 1'b0;
    end else if (accept && !is_mul) begin
      result_q <= single_res;
      err_q    <= !legal;
    end else if (mul_done) begin
      result_q <= mul_product;
    end else if (retire) begin
      err_q    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arith_op_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random vs model.
module tb_arith_op_sequencer;
  import arith_pkg::*;

  localparam int WIDTH = 4;
  localparam int M     = 1 << WIDTH;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               err;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;

  arith_op_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               res;
    bit               err;
    int               lat;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic on the command fields.
  function automatic void model(input int op_i, input int a_i, input int b_i,
                                output int res, output bit e, output int lat);
    int sa, w;
    res = 0; e = 1'b0; lat = 1;
    case (op_i)
      0: res = M - 1 - a_i;
      1: res = (M - a_i) % M;
      2: begin res = a_i * a_i; lat = WIDTH + 1; end
      3: begin res = a_i * b_i; lat = WIDTH + 1; end
      4: begin
        sa = (a_i >= M / 2) ? a_i - M : a_i;
        w  = 2 * sa;
        if (w >= M / 2) w -= M;
        if (w < -(M / 2)) w += M;
        res = (w + M * M) % (M * M);
      end
      default: e = 1'b1;
    endcase
  endfunction

  task automatic run_cmd(input string tag, input logic [2:0] o, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input int exp_res, input bit exp_err,
                         input int exp_lat);
    int cyc;
    check({tag, ".in_ready"}, 16'(in_ready), 16'd1);
    op = o; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, 16'(cyc), 16'(exp_lat));
    check({tag, ".result"}, 16'(result), 16'(exp_res));
    check({tag, ".err"}, 16'(err), 16'(exp_err));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".retired"}, 16'(out_valid), 16'd0);
    check({tag, ".err_cleared"}, 16'(err), 16'd0);
    check({tag, ".ready_after"}, 16'(in_ready), 16'd1);
  endtask

  vec_t vecs[10];

  initial begin
    int r_res, r_lat;
    bit r_err;
    logic [2:0] rop;
    logic [WIDTH-1:0] ra, rb;

    vecs[0] = '{3'd0, 4'h5, 4'h0, 8'h0A, 1'b0, 1};
    vecs[1] = '{3'd1, 4'h0, 4'h0, 8'h00, 1'b0, 1};
    vecs[2] = '{3'd1, 4'h1, 4'h0, 8'h0F, 1'b0, 1};
    vecs[3] = '{3'd3, 4'hF, 4'hF, 8'hE1, 1'b0, 5};
    vecs[4] = '{3'd2, 4'hC, 4'h3, 8'h90, 1'b0, 5};
    vecs[5] = '{3'd4, 4'hB, 4'h0, 8'h06, 1'b0, 1};
    vecs[6] = '{3'd4, 4'hE, 4'h0, 8'hFC, 1'b0, 1};
    vecs[7] = '{3'd6, 4'h7, 4'h2, 8'h00, 1'b1, 1};
    vecs[8] = '{3'd3, 4'h0, 4'h9, 8'h00, 1'b0, 5};
    vecs[9] = '{3'd3, 4'hD, 4'h0, 8'h00, 1'b0, 5};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    #12;
    check("reset.out_valid", 16'(out_valid), 16'd0);
    check("reset.result", 16'(result), 16'd0);
    check("reset.err", 16'(err), 16'd0);
    check("reset.busy", 16'(busy), 16'd0);
    check("reset.in_ready", 16'(in_ready), 16'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
              vecs[i].res, vecs[i].err, vecs[i].lat);

    // out_ready with nothing pending must not produce a result.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_ready.out_valid", 16'(out_valid), 16'd0);
    check("idle_ready.in_ready", 16'(in_ready), 16'd1);

    // Stall in DONE: result held, new command ignored, retire frees the block.
    op = 3'd3; a = 4'h3; b = 4'h4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin @(posedge clk); #1; end
    check("stall.out_valid", 16'(out_valid), 16'd1);
    op = 3'd0; a = 4'h0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d.result", i), 16'(result), 16'h0C);
      check($sformatf("stall%0d.in_ready", i), 16'(in_ready), 16'd0);
      check($sformatf("stall%0d.out_valid", i), 16'(out_valid), 16'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall.retire_ready", 16'(in_ready), 16'd1);
    check("stall.retire_valid", 16'(out_valid), 16'd0);
    @(posedge clk); #1;
    check("stall.not_queued", 16'(out_valid), 16'd0);

    // Reset during the second MUL cycle aborts the command.
    op = 3'd3; a = 4'h7; b = 4'h9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort.busy", 16'(busy), 16'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("abort.out_valid", 16'(out_valid), 16'd0);
    check("abort.result", 16'(result), 16'd0);
    check("abort.err", 16'(err), 16'd0);
    check("abort.busy_low", 16'(busy), 16'd0);
    check("abort.in_ready", 16'(in_ready), 16'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < WIDTH + 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("abort.quiet%0d", i), 16'(out_valid), 16'd0);
    end
    run_cmd("after_abort", 3'd3, 4'h3, 4'h5, 8'h0F, 1'b0, 5);

    // Reset while a result waits in DONE.
    op = 3'd0; a = 4'h2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("done_rst.pre", 16'(out_valid), 16'd1);
    rst_n = 1'b0;
    #2;
    check("done_rst.out_valid", 16'(out_valid), 16'd0);
    check("done_rst.result", 16'(result), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = WIDTH'($urandom_range(0, M - 1));
      rb  = WIDTH'($urandom_range(0, M - 1));
      model(int'(rop), int'(ra), int'(rb), r_res, r_err, r_lat);
      run_cmd($sformatf("rand%0d_op%0d_%0h_%0h", i, rop, ra, rb), rop, ra, rb, r_res, r_err, r_lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
